// File: rtl/lfsr_rng_if.sv
// Sample handshake bundle between lfsr_rng (master) and its consumer (slave).
// The bound signal and its modport entries exist only when LFSR_RNG_BOUND_EN is defined.
interface lfsr_rng_if #(
   parameter int unsigned WIDTH = 32'd13
);
   logic             en;
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] rnd;
   logic             rnd_valid;
   logic             rnd_ready;
`ifdef LFSR_RNG_BOUND_EN
   logic [WIDTH-1:0] bound;

   modport master (input en, seed_load, seed, rnd_ready, bound, output rnd, rnd_valid);
   modport slave  (output en, seed_load, seed, rnd_ready, bound, input rnd, rnd_valid);
`else
   modport master (input en, seed_load, seed, rnd_ready, output rnd, rnd_valid);
   modport slave  (output en, seed_load, seed, rnd_ready, input rnd, rnd_valid);
`endif
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci-LFSR random source: SHIFTS shifts per sample, seed reload, valid/ready output.
// Optional range rejection against bus.bound is enabled by defining LFSR_RNG_BOUND_EN.
module lfsr_rng #(
   parameter int unsigned     WIDTH  = 32'd13,
   parameter logic [WIDTH-1:0] TAPS  = 13'h100D,
   parameter logic [WIDTH-1:0] SEED  = 13'h000F,
   parameter int unsigned     SHIFTS = 32'd13
) (
   input  logic          clk_i,
   input  logic          rst_i,
   lfsr_rng_if.master    bus
);
   localparam int unsigned CNT_W = $clog2(SHIFTS + 32'd1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rnd_q, rnd_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] next_s;
   logic             accept_s;

   function automatic logic feedback(input logic [WIDTH-1:0] v);
      return ^(v & TAPS);
   endfunction

   assign next_s = {lfsr_q[WIDTH-2:0], feedback(lfsr_q)};

   // Range filter applied to the candidate at the capture edge; zero bound disables it.
`ifdef LFSR_RNG_BOUND_EN
   assign accept_s = (bus.bound == {WIDTH{1'b0}}) || (next_s < bus.bound);
`else
   assign accept_s = 1'b1;
`endif

   // Next-state logic: seed load overrides everything, then FILL/HOLD behaviour.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      rnd_d   = rnd_q;
      valid_d = valid_q;
      if (bus.seed_load) begin
         lfsr_d  = (bus.seed == {WIDTH{1'b0}}) ? SEED : bus.seed;
         cnt_d   = {CNT_W{1'b0}};
         valid_d = 1'b0;
         state_d = FILL;
      end else begin
         case (state_q)
            FILL: begin
               if (bus.en) begin
                  lfsr_d = next_s;
                  if (cnt_q == CNT_W'(SHIFTS - 32'd1)) begin
                     cnt_d = {CNT_W{1'b0}};
                     if (accept_s) begin
                        rnd_d   = next_s;
                        valid_d = 1'b1;
                        state_d = HOLD;
                     end else begin
                        state_d = FILL;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  lfsr_d = lfsr_q;
               end
            end
            HOLD: begin
               if (valid_q && bus.rnd_ready) begin
                  valid_d = 1'b0;
                  state_d = FILL;
               end else begin
                  state_d = HOLD;
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FILL;
         lfsr_q  <= SEED;
         cnt_q   <= {CNT_W{1'b0}};
         rnd_q   <= {WIDTH{1'b0}};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         rnd_q   <= rnd_d;
         valid_q <= valid_d;
      end
   end

   assign bus.rnd       = rnd_q;
   assign bus.rnd_valid = valid_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: default instance (SHIFTS=13) and a SHIFTS=1 instance.
// Bound-rejection steps are compiled in when LFSR_RNG_BOUND_EN is defined.
module tb_lfsr_rng;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   lfsr_rng_if #(.WIDTH(32'd13)) ifa ();
   lfsr_rng_if #(.WIDTH(32'd13)) ifb ();

   lfsr_rng dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifa)
   );

   lfsr_rng #(.SHIFTS(32'd1)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      ifa.en = 1'b1; ifa.seed_load = 1'b0; ifa.seed = 13'h0000; ifa.rnd_ready = 1'b1;
      ifb.en = 1'b0; ifb.seed_load = 1'b0; ifb.seed = 13'h0000; ifb.rnd_ready = 1'b1;
`ifdef LFSR_RNG_BOUND_EN
      ifa.bound = 13'h0000;
      ifb.bound = 13'h0000;
`endif
      #1;
      chk("reset_rnd", 32'(ifa.rnd), 32'h0000);
      chk("reset_valid", 32'(ifa.rnd_valid), 32'h0);
      tick();
      tick();
      chk("reset_hold_valid", 32'(ifa.rnd_valid), 32'h0);
      rst = 1'b0;

      // First sample of the default instance after 13 edges.
      for (int i = 0; i < 12; i++) tick();
      chk("first_pre_valid", 32'(ifa.rnd_valid), 32'h0);
      tick();
      chk("first_valid", 32'(ifa.rnd_valid), 32'h1);
      chk("first_rnd", 32'(ifa.rnd), 32'h1FF4);

      // SHIFTS=1 streaming: a sample every second edge.
      ifb.en = 1'b1;
      do_reset();
      tick();
      chk("s1_a_valid", 32'(ifb.rnd_valid), 32'h1);
      chk("s1_a_rnd", 32'(ifb.rnd), 32'h001F);
      tick();
      chk("s1_gap_valid", 32'(ifb.rnd_valid), 32'h0);
      tick();
      chk("s1_b_rnd", 32'(ifb.rnd), 32'h003F);
      tick();
      tick();
      chk("s1_c_valid", 32'(ifb.rnd_valid), 32'h1);
      chk("s1_c_rnd", 32'(ifb.rnd), 32'h007F);

      // Back-pressure: sample held for 10 cycles, nothing lost afterwards.
      ifb.rnd_ready = 1'b0;
      do_reset();
      tick();
      chk("bp_first_rnd", 32'(ifb.rnd), 32'h001F);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", 32'(ifb.rnd_valid), 32'h1);
         chk("bp_hold_rnd", 32'(ifb.rnd), 32'h001F);
      end
      ifb.rnd_ready = 1'b1;
      tick();
      chk("bp_release_valid", 32'(ifb.rnd_valid), 32'h0);
      tick();
      chk("bp_next_valid", 32'(ifb.rnd_valid), 32'h1);
      chk("bp_next_rnd", 32'(ifb.rnd), 32'h003F);

      // Zero seed load while holding a sample falls back to SEED.
      ifb.rnd_ready = 1'b0;
      ifb.seed_load = 1'b1;
      ifb.seed = 13'h0000;
      tick();
      chk("sl0_valid", 32'(ifb.rnd_valid), 32'h0);
      chk("sl0_rnd_kept", 32'(ifb.rnd), 32'h003F);
      ifb.seed_load = 1'b0;
      ifb.rnd_ready = 1'b1;
      tick();
      chk("sl0_next_rnd", 32'(ifb.rnd), 32'h001F);
      ifb.seed_load = 1'b1;
      ifb.seed = 13'h0001;
      tick();
      chk("sl1_valid", 32'(ifb.rnd_valid), 32'h0);
      ifb.seed_load = 1'b0;
      tick();
      chk("sl1_next_valid", 32'(ifb.rnd_valid), 32'h1);
      chk("sl1_next_rnd", 32'(ifb.rnd), 32'h0003);

      // en low for 5 cycles mid-FILL delays the sample by exactly 5 cycles.
      ifa.en = 1'b1;
      ifa.rnd_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      ifa.en = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("en_low_valid", 32'(ifa.rnd_valid), 32'h0);
      ifa.en = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      chk("en_pre_valid", 32'(ifa.rnd_valid), 32'h0);
      tick();
      chk("en_valid", 32'(ifa.rnd_valid), 32'h1);
      chk("en_rnd", 32'(ifa.rnd), 32'h1FF4);

      // Asynchronous reset between clock edges.
      ifa.rnd_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 32'(ifa.rnd_valid), 32'h0);
      chk("async_rnd", 32'(ifa.rnd), 32'h0000);
      #2 rst = 1'b0;
      ifa.rnd_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("async_pre_valid", 32'(ifa.rnd_valid), 32'h0);
      tick();
      chk("async_after_rnd", 32'(ifa.rnd), 32'h1FF4);

`ifdef LFSR_RNG_BOUND_EN
      // Candidates at or above bound are never presented.
      ifb.bound = 13'h0040;
      do_reset();
      tick();
      chk("bnd_a_rnd", 32'(ifb.rnd), 32'h001F);
      tick();
      tick();
      chk("bnd_b_rnd", 32'(ifb.rnd), 32'h003F);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("bnd_reject_valid", 32'(ifb.rnd_valid), 32'h0);
      end
      ifb.bound = 13'h0000;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      chk("bnd0_valid", 32'(ifb.rnd_valid), 32'h1);
      chk("bnd0_rnd", 32'(ifb.rnd), 32'h007F);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Fibonacci-LFSR random-number source with a reloadable seed, a configurable number of shifts per sample, and a valid/ready output handshake. Samples are held stable until consumed. It is the successor to the fixed 13-bit generator: it generalises width and taps and adds seed loading, back-pressure and optional range rejection. Game-logic blocks use it as their shared source of pseudo-random values.

## Interface
- WIDTH, 13: LFSR and sample width, 3..32.
- TAPS, 13'h100D: feedback mask; bit i set means state bit i feeds the XOR.
- SEED, 13'h000F: reset value and fallback seed; must be non-zero.
- SHIFTS, 13: LFSR shifts per delivered sample, 1..64.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- en  in  1  permits shifting while in FILL.
- seed_load  in  1  one-cycle request to load `seed`.
- seed  in  WIDTH  seed value; zero is replaced by SEED.
- rnd  out  WIDTH  current sample, stable while rnd_valid=1.
- rnd_valid  out  1  sample available.
- rnd_ready  in  1  consumer accepts the sample.
- bound  in  WIDTH  exclusive upper limit; present only with LFSR_RNG_BOUND_EN.

## Operation
- Next-state function: next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}, a left shift with feedback into bit 0.
- Shift counter `cnt` has width clog2(SHIFTS+1).
- State FILL:
  - en=1: lfsr <= next and cnt <= cnt+1.
  - en=0: lfsr and cnt freeze.
  - When a shift occurs with cnt==SHIFTS-1: rnd <= next (the post-shift value), rnd_valid <= 1, cnt <= 0, go to HOLD.
- State HOLD:
  - The LFSR does not shift, whatever the value of en.
  - On rnd_valid & rnd_ready: rnd_valid <= 0, go to FILL. rnd keeps its last value.
- seed_load has the highest priority, in either state:
  - lfsr <= (seed==0 ? SEED : seed), cnt <= 0, rnd_valid <= 0, state <= FILL.
  - Any pending sample is discarded. A coincident handshake is treated as complete.
- The all-zero LFSR state is therefore unreachable: reset gives SEED, and a zero load is replaced by SEED.
- Reset values: lfsr=SEED, cnt=0, state=FILL, rnd=0, rnd_valid=0.
- Reset asserted mid-operation returns everything to these values immediately, without waiting for a clock edge.

## Timing
- First sample: rnd_valid rises on the edge that performs the SHIFTS-th enabled shift after reset or seed_load. With en held high, that is the SHIFTS-th edge.
- Steady state, with en=1 and rnd_ready held high: one sample every SHIFTS+1 cycles.
  - SHIFTS edges are spent in FILL.
  - One edge is spent completing the handshake in HOLD.
- rnd_ready may be high before rnd_valid. Only the cycle in which both are high counts as a transfer.
- rnd and rnd_valid are registered outputs with no combinational path from inputs.
- The seed_load effect is visible on the next edge.

## Configuration
- LFSR_RNG_BOUND_EN defined:
  - The `bound` port exists.
  - At the capture point, a candidate with next >= bound is rejected: cnt <= 0, state stays FILL, rnd_valid stays 0, and the LFSR keeps the shifted value.
  - bound==0 disables rejection.
  - bound is sampled only at the capture edge.
- LFSR_RNG_BOUND_EN not defined:
  - No `bound` port.
  - Every capture is delivered.

## Test plan
- Default parameters, reset released, en=1, rnd_ready=1 -> rnd=0x0000 and rnd_valid=0 during reset; first rnd_valid after 13 edges with rnd=0x1FF4.
- SHIFTS=1, en=1, rnd_ready=1 -> samples 0x001F, 0x003F, 0x007F, arriving on every second edge.
- SHIFTS=1, rnd_ready=0 for 10 cycles after the first sample -> rnd holds 0x001F with rnd_valid=1. After ready is raised, the next sample is 0x003F, with no shifts lost or skipped.
- seed_load=1, seed=0 while in HOLD -> rnd_valid drops the next cycle and the LFSR equals 0x000F. With SHIFTS=1 the next sample is 0x001F.
- en toggled low mid-FILL for 5 cycles; reset pulsed during FILL with no clock edge -> sample delayed by exactly 5 cycles; asynchronous reset forces rnd_valid=0 and rnd=0 immediately.
- LFSR_RNG_BOUND_EN defined, SHIFTS=1, bound=0x40 -> 0x001F and 0x003F delivered; 0x007F not presented. With bound=0 -> 0x007F is delivered.
